// File: rtl/dds_phase_acc.sv
// DDS phase accumulator generating sine-ROM addresses with a tuning-word handshake.
// Define DDS_SWEEP_EN to add the linear tuning-word sweep FSM.
module dds_phase_acc #(
    parameter int unsigned       ACC_W   = 32,
    parameter logic [ACC_W-1:0]  FTW_RST = ACC_W'(1) << (ACC_W - 10),
    parameter int unsigned       DWELL   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [9:0]       cfg_pofs,
    input  logic             cfg_phase_clr,
    input  logic             sweep_start,
    input  logic [ACC_W-1:0] sweep_step,
    input  logic [ACC_W-1:0] sweep_end,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [10:0]      rom_addr,
    output logic             wrap
);

    typedef enum logic {S_NORM, S_SWEEP} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ftw;
    logic [ACC_W-1:0] ftw_nxt;
    logic [9:0]       pofs;
    logic [9:0]       idx;
    logic             carry_q;
    logic             done_q;
    logic             done_nxt;
    logic [ACC_W:0]   sum;
    logic             accept;

    assign cfg_ready  = (state == S_NORM);
    assign sweep_busy = (state == S_SWEEP);
    assign sweep_done = done_q;
    assign accept     = cfg_valid && cfg_ready;
    assign sum        = {1'b0, acc} + {1'b0, ftw};
    assign rom_addr   = {1'b0, idx};

    // Phase clear wins over the add and suppresses its carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (accept && cfg_phase_clr) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            acc     <= sum[ACC_W-1:0];
            carry_q <= sum[ACC_W];
        end else begin
            carry_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            wrap <= 1'b0;
        end else begin
            idx  <= acc[ACC_W-1 -: 10] + pofs;
            wrap <= carry_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pofs   <= '0;
            ftw    <= FTW_RST;
            done_q <= 1'b0;
        end else begin
            if (accept) pofs <= cfg_pofs;
            ftw    <= ftw_nxt;
            done_q <= done_nxt;
        end
    end

`ifdef DDS_SWEEP_EN
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ACC_W:0]   step_sum;
    logic             roll;

    assign step_sum = {1'b0, ftw} + {1'b0, sweep_step};
    assign roll     = (cnt == CNT_W'(DWELL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_NORM;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ftw_nxt   = ftw;
        done_nxt  = 1'b0;
        unique case (state)
            S_NORM: begin
                if (accept) begin
                    ftw_nxt = cfg_ftw;
                end else if (sweep_start) begin
                    if (sweep_end > ftw) begin
                        state_nxt = S_SWEEP;
                        cnt_nxt   = '0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                cnt_nxt = roll ? '0 : cnt + 1'b1;
                if (roll) begin
                    if (step_sum >= {1'b0, sweep_end}) begin
                        ftw_nxt   = sweep_end;
                        state_nxt = S_NORM;
                        done_nxt  = 1'b1;
                    end else begin
                        ftw_nxt = step_sum[ACC_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end
`else
    logic unused_sweep;

    assign state        = S_NORM;
    assign ftw_nxt      = accept ? cfg_ftw : ftw;
    assign done_nxt     = 1'b0;
    assign unused_sweep = ^{sweep_start, sweep_step, sweep_end};
`endif

endmodule

// File: tb/tb_dds_phase_acc.sv
// Self-checking bench for dds_phase_acc: cycle model plus hand-computed checks.
// Sweep scenarios run only when DDS_SWEEP_EN is defined.
module tb_dds_phase_acc;

    localparam int     ACC_W = 32;
    localparam int     DWELL = 4;
    localparam longint MOD   = 64'd1 << ACC_W;
    localparam longint FTWR  = 64'd1 << (ACC_W - 10);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_ftw;
    logic [9:0]       cfg_pofs;
    logic             cfg_phase_clr;
    logic             sweep_start;
    logic [ACC_W-1:0] sweep_step;
    logic [ACC_W-1:0] sweep_end;
    logic             sweep_busy;
    logic             sweep_done;
    logic [10:0]      rom_addr;
    logic             wrap;

    int n_chk = 0;
    int n_err = 0;

    dds_phase_acc #(.ACC_W(ACC_W), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ftw(cfg_ftw), .cfg_pofs(cfg_pofs),
        .cfg_phase_clr(cfg_phase_clr),
        .sweep_start(sweep_start), .sweep_step(sweep_step),
        .sweep_end(sweep_end), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .rom_addr(rom_addr), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: phase as an integer modulo 2^ACC_W, sweep as a
    // schedule ftw = min(end, base + step * floor(t / DWELL)).
    longint m_acc = 0, m_ftw = FTWR, m_pofs = 0, m_sum = 0;
    longint m_base = 0, m_step = 0, m_end = 0;
    bit     m_carry = 0, m_sw = 0, m_take = 0;
    int     m_t = 0;
    int     e_addr = 0;
    bit     e_wrap = 0, e_done = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = 0; m_ftw = FTWR; m_pofs = 0; m_carry = 0;
            m_sw = 0; m_t = 0; e_addr = 0; e_wrap = 0; e_done = 0;
        end else begin
            e_addr = int'(((m_acc >> (ACC_W - 10)) + m_pofs) % 1024);
            e_wrap = m_carry;
            e_done = 0;
            m_take = cfg_valid && !m_sw;
            m_sum  = m_acc + m_ftw;
            if (m_take && cfg_phase_clr) begin
                m_acc = 0; m_carry = 0;
            end else if (en) begin
                m_carry = (m_sum >= MOD);
                m_acc   = m_sum % MOD;
            end else begin
                m_carry = 0;
            end
            if (m_take) begin
                m_ftw  = longint'(cfg_ftw);
                m_pofs = longint'(cfg_pofs);
            end else if (m_sw) begin
                m_t++;
                if (m_t % DWELL == 0) begin
                    m_ftw = m_base + m_step * (m_t / DWELL);
                    if (m_ftw >= m_end) begin
                        m_ftw = m_end; m_sw = 0; e_done = 1;
                    end
                end
            end
`ifdef DDS_SWEEP_EN
            else if (sweep_start) begin
                if (longint'(sweep_end) > m_ftw) begin
                    m_sw = 1; m_t = 0; m_base = m_ftw;
                    m_step = longint'(sweep_step);
                    m_end  = longint'(sweep_end);
                end else begin
                    e_done = 1;
                end
            end
`endif
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cycle", {rom_addr, wrap, sweep_busy, sweep_done, cfg_ready},
            {11'(e_addr), e_wrap, m_sw, e_done, !m_sw});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int wq[$];
    int n_done;
    int done_t;
    bit found;
    bit busy11;
    bit busy12;

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ftw = '0;
        cfg_pofs = '0; cfg_phase_clr = 1'b0; sweep_start = 1'b0;
        sweep_step = '0; sweep_end = '0;
        tick(); tick();
        chk("rst_addr", rom_addr, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_busy", sweep_busy, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_ready", cfg_ready, 1);

        // Default tuning word: one ROM entry per clock.
        @(negedge clk); rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 2100; k++) begin
            tick();
            if (k == 1) chk("step_k1", rom_addr, 0);
            if (k == 3) chk("step_k3", rom_addr, 2);
            if (wrap) begin
                wq.push_back(k);
                chk("wrap_at_zero", rom_addr, 0);
            end
        end
        chk("wrap_count", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("wrap_first", wq[0], 1025);
            chk("wrap_period", wq[1] - wq[0], 1024);
        end

        // Hold the phase with en low.
        found = 0;
        for (int k = 0; k < 1100 && !found; k++) begin
            tick();
            if (rom_addr == 11'd299) found = 1;
        end
        chk("find_299", found, 1);
        @(negedge clk); en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_addr", rom_addr, 300);
            chk("hold_wrap", wrap, 0);
        end
        @(negedge clk); en = 1'b1;
        tick(); chk("resume_a", rom_addr, 300);
        tick(); chk("resume_b", rom_addr, 301);

        // New tuning word, offset and phase clear.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ftw = 32'h0080_0000;
        cfg_pofs = 10'd256; cfg_phase_clr = 1'b1;
        tick();
        @(negedge clk); cfg_valid = 1'b0; cfg_phase_clr = 1'b0;
        wq.delete();
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (k == 1) chk("cfg_k1", rom_addr, 256);
            if (k == 2) chk("cfg_k2", rom_addr, 258);
            if (k == 3) chk("cfg_k3", rom_addr, 260);
            if (wrap) wq.push_back(k);
        end
        chk("wrap2_count", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("wrap2_first", wq[0], 513);
            chk("wrap2_period", wq[1] - wq[0], 512);
        end

        // Configuration and sweep_start together: configuration wins.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ftw = 32'h0040_0000; cfg_pofs = 10'd0;
        sweep_start = 1'b1; sweep_step = 32'h0010_0000;
        sweep_end = 32'h0080_0000;
        tick();
        @(negedge clk); cfg_valid = 1'b0; sweep_start = 1'b0;
        chk("both_busy", sweep_busy, 0);
        chk("both_ready", cfg_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("both_nodone", sweep_done, 0);
            chk("both_nobusy", sweep_busy, 0);
        end

`ifdef DDS_SWEEP_EN
        // Three-step sweep, with an ignored configuration attempt.
        @(negedge clk);
        sweep_end = 32'h0070_0000; sweep_start = 1'b1;
        tick();
        chk("sw_busy0", sweep_busy, 1);
        chk("sw_ready0", cfg_ready, 0);
        @(negedge clk); sweep_start = 1'b0;
        n_done = 0; done_t = 0; busy11 = 0; busy12 = 1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (sweep_done) begin n_done++; done_t = t; end
            if (t == 11) busy11 = sweep_busy;
            if (t == 12) busy12 = sweep_busy;
            if (t == 5) begin
                @(negedge clk);
                cfg_valid = 1'b1; cfg_ftw = 32'd12345; cfg_phase_clr = 1'b1;
            end
            if (t == 6) begin
                @(negedge clk); cfg_valid = 1'b0; cfg_phase_clr = 1'b0;
            end
        end
        chk("sw_ndone", n_done, 1);
        chk("sw_done_t", done_t, 12);
        chk("sw_busy11", busy11, 1);
        chk("sw_busy12", busy12, 0);

        // End not above current word: immediate done, no sweep.
        @(negedge clk); sweep_end = 32'h0040_0000; sweep_start = 1'b1;
        tick();
        chk("nosw_done", sweep_done, 1);
        chk("nosw_busy", sweep_busy, 0);
        @(negedge clk); sweep_start = 1'b0;
        tick();
        chk("nosw_done2", sweep_done, 0);

        // Reset in the middle of a sweep.
        @(negedge clk); sweep_end = 32'h00F0_0000; sweep_start = 1'b1;
        tick();
        @(negedge clk); sweep_start = 1'b0;
        tick(); tick();
        chk("mid_busy", sweep_busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_addr", rom_addr, 0);
        chk("arst_busy", sweep_busy, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_wrap", wrap, 0);
        chk("arst_done", sweep_done, 0);
        @(negedge clk); rst = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_step", rom_addr, 2);
`else
        @(negedge clk); sweep_end = 32'h00F0_0000; sweep_start = 1'b1;
        tick();
        chk("nomac_busy", sweep_busy, 0);
        @(negedge clk); sweep_start = 1'b0;
        tick();
        chk("nomac_done", sweep_done, 0);
        chk("nomac_ready", cfg_ready, 1);
`endif

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
